imm_issue_ctl: RTL and testbench

IMM_ISSUE_CTL -- requirements
Module: imm_issue_ctl

---
 rtl/imm_issue_ctl.sv | 183 ++++++++++++++++++
 tb/tb_imm_issue_ctl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_issue_ctl.sv
// Issue control for the immediate-load instructions 020-023 (A destination) and 040/041 (S destination).
// It captures the parcels, waits out reservations, strobes the generator for one cycle, then writes back.
module imm_issue_ctl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_issue_vld,
   input  logic [15:0] i_parcel,
   output logic        o_issue_rdy,
   input  logic        i_lip_vld,
   input  logic [15:0] i_lip,
   output logic        o_lip_rdy,
   input  logic [7:0]  i_a_resv,
   input  logic [7:0]  i_s_resv,
   input  logic        i_fu_a_wb,
   input  logic        i_fu_s_wb,
   output logic [6:0]  o_gen_instr,
   output logic [2:0]  o_gen_j,
   output logic [2:0]  o_gen_k,
   output logic [15:0] o_gen_lip,
   output logic        o_a_we,
   output logic [2:0]  o_a_waddr,
   output logic        o_s_we,
   output logic [2:0]  o_s_waddr,
   output logic [2:0]  o_sj_addr,
   output logic        o_busy,
   output logic        o_illegal,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LIP  = 3'd1,
      ST_CHK  = 3'd2,
      ST_GEN  = 3'd3,
      ST_WB   = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [6:0]  op_q;
   logic [2:0]  i_q;
   logic [2:0]  j_q;
   logic [2:0]  k_q;
   logic [15:0] lip_q;
   logic        illegal_q;

   logic [6:0]  in_op;
   logic        in_two;
   logic        in_one;
   logic        accept;
   logic        lip_take;
   logic        cap_s;
   logic        cap_two;
   logic        dest_resv;
   logic        sj_resv;
   logic        chk_ok;

   // Handshakes: a parcel transfers on a cycle where its valid and ready are both high at posedge;
   // ready never depends on the parcel contents, and valid outside the ready window is ignored.
   assign accept   = i_issue_vld & (state == ST_IDLE);
   assign lip_take = i_lip_vld & (state == ST_LIP);

   assign in_op = i_parcel[15:9];

   always_comb begin
      in_two = 1'b0;
      in_one = 1'b0;
      case (in_op)
         7'o020, 7'o021, 7'o040, 7'o041: in_two = 1'b1;
         7'o022, 7'o023:                 in_one = 1'b1;
         default: ;
      endcase
   end

   assign cap_s   = (op_q == 7'o040) || (op_q == 7'o041);
   assign cap_two = cap_s || (op_q == 7'o020) || (op_q == 7'o021);

   // 023 also reads Sj, so it must wait for that register as well as its A destination.
   assign dest_resv = cap_s ? i_s_resv[i_q] : i_a_resv[i_q];
   assign sj_resv   = (op_q == 7'o023) & i_s_resv[j_q];
   assign chk_ok    = ~dest_resv & ~sj_resv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= 7'o000;
         i_q       <= 3'd0;
         j_q       <= 3'd0;
         k_q       <= 3'd0;
         lip_q     <= 16'h0000;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= accept & ~in_two & ~in_one;
         if (accept) begin
            op_q  <= in_op;
            i_q   <= i_parcel[8:6];
            j_q   <= i_parcel[5:3];
            k_q   <= i_parcel[2:0];
            lip_q <= 16'h0000;
         end else if (lip_take) begin
            lip_q <= i_lip;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      o_issue_rdy = 1'b0;
      o_lip_rdy   = 1'b0;
      o_gen_instr = 7'o000;
      o_gen_j     = 3'd0;
      o_gen_k     = 3'd0;
      o_gen_lip   = 16'h0000;
      o_a_we      = 1'b0;
      o_a_waddr   = 3'd0;
      o_s_we      = 1'b0;
      o_s_waddr   = 3'd0;
      o_sj_addr   = 3'd0;
      case (state)
         ST_IDLE: begin
            o_issue_rdy = 1'b1;
            if (i_issue_vld) begin
               if (in_two) begin
                  state_nxt = ST_LIP;
               end else if (in_one) begin
                  state_nxt = ST_CHK;
               end
            end
         end
         ST_LIP: begin
            o_lip_rdy = 1'b1;
            if (i_lip_vld) begin
               state_nxt = ST_CHK;
            end
         end
         ST_CHK: begin
            o_sj_addr = j_q;
            if (chk_ok) begin
               state_nxt = ST_GEN;
            end
         end
         ST_GEN: begin
            o_sj_addr   = j_q;
            o_gen_instr = op_q;
            o_gen_j     = j_q;
            o_gen_k     = k_q;
            o_gen_lip   = cap_two ? lip_q : 16'h0000;
            state_nxt   = ST_WB;
         end
         ST_WB: begin
            // A functional unit owning the write port wins; retry every cycle until it lets go.
            o_sj_addr = j_q;
            if (cap_s) begin
               o_s_waddr = i_q;
               if (!i_fu_s_wb) begin
                  o_s_we    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else begin
               o_a_waddr = i_q;
               if (!i_fu_a_wb) begin
                  o_a_we    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign o_busy    = (state != ST_IDLE);
   assign o_illegal = illegal_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_imm_issue_ctl.sv
// Bench for imm_issue_ctl: vector table, multi-cycle corner sequences, then random traffic
// scored against a transaction-level model of accepted instructions and their expected effects.
module tb_imm_issue_ctl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_issue_vld;
   logic [15:0] i_parcel;
   logic        o_issue_rdy;
   logic        i_lip_vld;
   logic [15:0] i_lip;
   logic        o_lip_rdy;
   logic [7:0]  i_a_resv;
   logic [7:0]  i_s_resv;
   logic        i_fu_a_wb;
   logic        i_fu_s_wb;
   logic [6:0]  o_gen_instr;
   logic [2:0]  o_gen_j;
   logic [2:0]  o_gen_k;
   logic [15:0] o_gen_lip;
   logic        o_a_we;
   logic [2:0]  o_a_waddr;
   logic        o_s_we;
   logic [2:0]  o_s_waddr;
   logic [2:0]  o_sj_addr;
   logic        o_busy;
   logic        o_illegal;
   logic [2:0]  dbg_state;

   imm_issue_ctl dut (
      .clk(clk), .rst_n(rst_n),
      .i_issue_vld(i_issue_vld), .i_parcel(i_parcel), .o_issue_rdy(o_issue_rdy),
      .i_lip_vld(i_lip_vld), .i_lip(i_lip), .o_lip_rdy(o_lip_rdy),
      .i_a_resv(i_a_resv), .i_s_resv(i_s_resv),
      .i_fu_a_wb(i_fu_a_wb), .i_fu_s_wb(i_fu_s_wb),
      .o_gen_instr(o_gen_instr), .o_gen_j(o_gen_j), .o_gen_k(o_gen_k), .o_gen_lip(o_gen_lip),
      .o_a_we(o_a_we), .o_a_waddr(o_a_waddr), .o_s_we(o_s_we), .o_s_waddr(o_s_waddr),
      .o_sj_addr(o_sj_addr), .o_busy(o_busy), .o_illegal(o_illegal), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] RST_OUTS = 64'h1 << 43;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   function automatic logic [63:0] outs();
      return {20'b0, o_issue_rdy, o_lip_rdy, o_gen_instr, o_gen_j, o_gen_k, o_gen_lip,
              o_a_we, o_a_waddr, o_s_we, o_s_waddr, o_sj_addr, o_busy, o_illegal};
   endfunction

   task automatic idle_inputs();
      i_issue_vld = 1'b0;
      i_parcel    = 16'h0000;
      i_lip_vld   = 1'b0;
      i_lip       = 16'h0000;
      i_a_resv    = 8'h00;
      i_s_resv    = 8'h00;
      i_fu_a_wb   = 1'b0;
      i_fu_s_wb   = 1'b0;
   endtask

   // ---------------- reference model ----------------
   // 0 = unsupported, 1 = one parcel, 2 = two parcels
   function automatic int kind_of(input logic [6:0] op);
      case (op)
         7'o020, 7'o021, 7'o040, 7'o041: return 2;
         7'o022, 7'o023:                 return 1;
         default:                        return 0;
      endcase
   endfunction

   function automatic logic writes_s(input logic [6:0] op);
      return (op == 7'o040) || (op == 7'o041);
   endfunction

   logic [3:0]  wr_q[$];    // {is_s, waddr}
   logic [31:0] gen_q[$];   // {op, i, j, k, lip}
   logic        ill_exp  = 1'b0;
   logic        lip_wait = 1'b0;
   logic [15:0] pend;
   logic [7:0]  prev_ar  = 8'h00;
   logic [7:0]  prev_sr  = 8'h00;

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [31:0] e;
      logic [3:0]  w;
      logic [6:0]  op;
      logic        blocked;
      if (!rst_n) begin
         wr_q.delete();
         gen_q.delete();
         ill_exp  = 1'b0;
         lip_wait = 1'b0;
      end else begin
         chk("illegal_pulse", o_illegal, ill_exp);
         ill_exp = 1'b0;
         chk("lip_rdy_window", o_lip_rdy, lip_wait);
         chk("we_exclusive", o_a_we & o_s_we, 0);
         if (o_gen_instr != 7'o000) begin
            chk("gen_expected", gen_q.size(), 1);
            if (gen_q.size() != 0) begin
               e = gen_q.pop_front();
               chk("gen_fields", {o_gen_instr, o_gen_j, o_gen_k, o_gen_lip},
                   {e[31:25], e[21:16], e[15:0]});
               blocked = writes_s(e[31:25]) ? prev_sr[e[24:22]] : prev_ar[e[24:22]];
               if (e[31:25] == 7'o023) blocked = blocked | prev_sr[e[21:19]];
               chk("gen_after_resv_clear", blocked, 0);
            end
         end
         if (o_a_we || o_s_we) begin
            chk("we_vs_fu", (o_a_we & i_fu_a_wb) | (o_s_we & i_fu_s_wb), 0);
            chk("write_expected", wr_q.size(), 1);
            if (wr_q.size() != 0) begin
               w = wr_q.pop_front();
               chk("write_target", {o_s_we, o_s_we ? o_s_waddr : o_a_waddr}, w);
            end
         end
         if (lip_wait && i_lip_vld && o_lip_rdy) begin
            gen_q.push_back({pend, i_lip});
            lip_wait = 1'b0;
         end
         if (i_issue_vld && o_issue_rdy) begin
            op = i_parcel[15:9];
            case (kind_of(op))
               0: ill_exp = 1'b1;
               1: begin
                  wr_q.push_back({writes_s(op), i_parcel[8:6]});
                  gen_q.push_back({i_parcel, 16'h0000});
               end
               default: begin
                  wr_q.push_back({writes_s(op), i_parcel[8:6]});
                  pend     = i_parcel;
                  lip_wait = 1'b1;
               end
            endcase
         end
         prev_ar = i_a_resv;
         prev_sr = i_s_resv;
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [6:0]  op;
      logic        two;
      logic [2:0]  i;
      logic [2:0]  j;
      logic [2:0]  k;
      logic [15:0] lip;
      logic [6:0]  exp_gen;
      logic [15:0] exp_lip;
      logic        exp_a;
      logic        exp_s;
      logic        exp_ill;
   } vec_t;

   vec_t       vecs[9];
   logic [2:0] idle_code;

   // Starts in the current cycle and leaves off at the start of the cycle after the write,
   // so consecutive calls exercise back-to-back issue.
   task automatic run_vec(input vec_t v);
      i_issue_vld = 1'b1;
      i_parcel    = {v.op, v.i, v.j, v.k};
      settle();
      chk("v_issue_rdy", o_issue_rdy, 1);
      tick();
      i_issue_vld = 1'b0;
      if (v.exp_ill) begin
         settle();
         chk("v_illegal", {o_illegal, o_issue_rdy, o_busy}, 3'b110);
         tick();
         settle();
         chk("v_illegal_once", {o_illegal, o_a_we, o_s_we, o_issue_rdy}, 4'b0001);
         tick();
         return;
      end
      if (v.two) begin
         i_lip_vld = 1'b1;
         i_lip     = v.lip;
         settle();
         chk("v_lip_rdy", {o_lip_rdy, o_busy}, 2'b11);
         tick();
         i_lip_vld = 1'b0;
         i_lip     = 16'h0000;
      end
      settle();
      chk("v_chk", {o_busy, o_issue_rdy, o_gen_instr, o_sj_addr}, {1'b1, 1'b0, 7'o000, v.j});
      chk("v_dbg_busy", dbg_state != idle_code, 1);
      tick();
      settle();
      chk("v_gen", {o_gen_instr, o_gen_j, o_gen_k, o_gen_lip}, {v.exp_gen, v.j, v.k, v.exp_lip});
      tick();
      settle();
      chk("v_wb", {o_a_we, o_s_we, (v.exp_s ? o_s_waddr : o_a_waddr)}, {v.exp_a, v.exp_s, v.i});
      tick();
   endtask

   // ---------------- corner sequences ----------------
   task automatic seq_lip_late();
      i_issue_vld = 1'b1;
      i_parcel    = {7'o020, 3'd1, 3'd7, 3'd7};
      i_lip_vld   = 1'b1;
      i_lip       = 16'hDEAD;
      settle();
      chk("late_accept", {o_issue_rdy, o_lip_rdy}, 2'b10);
      tick();
      i_issue_vld = 1'b0;
      i_lip_vld   = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         settle();
         chk("late_lip_wait", {o_lip_rdy, o_busy, o_gen_instr}, {1'b1, 1'b1, 7'o000});
         tick();
      end
      i_lip_vld = 1'b1;
      i_lip     = 16'hABCD;
      settle();
      chk("late_lip_take", o_lip_rdy, 1);
      tick();
      i_lip_vld = 1'b1;
      i_lip     = 16'h1111;
      settle();
      chk("late_chk", {o_lip_rdy, o_gen_instr, o_sj_addr}, {1'b0, 7'o000, 3'd7});
      tick();
      i_lip_vld = 1'b0;
      settle();
      chk("late_gen", {o_gen_instr, o_gen_lip}, {7'o020, 16'hABCD});
      tick();
      settle();
      chk("late_wb", {o_a_we, o_a_waddr, o_s_we}, {1'b1, 3'd1, 1'b0});
      tick();
   endtask

   task automatic seq_fu_stall();
      i_issue_vld = 1'b1;
      i_parcel    = {7'o040, 3'd6, 3'd0, 3'd0};
      tick();
      i_issue_vld = 1'b0;
      i_lip_vld   = 1'b1;
      i_lip       = 16'h5555;
      tick();
      i_lip_vld = 1'b0;
      tick();
      settle();
      chk("stall_gen", {o_gen_instr, o_gen_lip}, {7'o040, 16'h5555});
      tick();
      i_fu_s_wb = 1'b1;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk("stall_hold", {o_s_we, o_a_we, o_busy}, 3'b001);
         tick();
      end
      i_fu_s_wb = 1'b0;
      i_fu_a_wb = 1'b1;
      settle();
      chk("stall_release", {o_s_we, o_s_waddr, o_a_we}, {1'b1, 3'd6, 1'b0});
      tick();
      i_fu_a_wb = 1'b0;
      settle();
      chk("stall_done", {o_s_we, o_busy}, 2'b00);
      tick();
   endtask

   task automatic seq_resv();
      i_s_resv    = 8'h10;
      i_a_resv    = 8'h20;
      i_issue_vld = 1'b1;
      i_parcel    = {7'o023, 3'd2, 3'd4, 3'd1};
      tick();
      i_issue_vld = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c == 5) i_s_resv = 8'h00;
         settle();
         chk("resv_hold", {o_gen_instr, o_sj_addr, o_busy}, {7'o000, 3'd4, 1'b1});
         tick();
      end
      settle();
      chk("resv_gen", {o_gen_instr, o_gen_j, o_gen_k, o_gen_lip, o_sj_addr},
          {7'o023, 3'd4, 3'd1, 16'h0000, 3'd4});
      tick();
      settle();
      chk("resv_wb", {o_a_we, o_a_waddr, o_sj_addr}, {1'b1, 3'd2, 3'd4});
      tick();
      i_a_resv = 8'h00;
      settle();
      chk("resv_done", {o_sj_addr, o_busy}, {3'd0, 1'b0});
      tick();
   endtask

   task automatic seq_reset_wb();
      i_fu_a_wb   = 1'b1;
      i_issue_vld = 1'b1;
      i_parcel    = {7'o022, 3'd3, 3'd0, 3'd0};
      tick();
      i_issue_vld = 1'b0;
      tick();
      tick();
      settle();
      chk("rst_fu_hold", {o_a_we, o_busy}, 2'b01);
      tick();
      #2 rst_n = 1'b0;
      #1 chk("rst_async", outs(), RST_OUTS);
      settle();
      chk("rst_held", outs(), RST_OUTS);
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("rst_no_we", {o_a_we, o_busy}, 2'b00);
         tick();
      end
      i_fu_a_wb = 1'b0;
      run_vec(vecs[0]);
      settle();
      chk("rst_fresh_done", {o_busy, o_issue_rdy}, 2'b01);
      tick();
   endtask

   // ---------------- random traffic ----------------
   logic [6:0]  ops[6];
   logic [6:0]  r_op;
   logic [15:0] cur_lip;
   logic        in_lip;
   int          n_issued;

   task automatic run_random();
      n_issued = 0;
      in_lip   = 1'b0;
      cur_lip  = 16'h0000;
      for (int c = 0; c < 6000; c++) begin
         if (n_issued >= 80 && !o_busy) break;
         i_a_resv  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         i_s_resv  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         i_fu_a_wb = ($urandom_range(0, 3) == 0);
         i_fu_s_wb = ($urandom_range(0, 3) == 0);
         i_lip_vld = 1'($urandom_range(0, 1));
         i_lip     = in_lip ? cur_lip : 16'($urandom);
         if (o_issue_rdy && n_issued < 80) begin
            if ($urandom_range(0, 7) == 0) begin
               do r_op = 7'($urandom_range(0, 127)); while (kind_of(r_op) != 0);
            end else begin
               r_op = ops[$urandom_range(0, 5)];
            end
            i_issue_vld = 1'b1;
            i_parcel    = {r_op, 9'($urandom)};
            n_issued++;
            if (kind_of(r_op) == 2) begin
               in_lip  = 1'b1;
               cur_lip = 16'($urandom);
            end
         end else if (!o_issue_rdy) begin
            i_issue_vld = 1'($urandom_range(0, 1));
            i_parcel    = 16'($urandom);
         end else begin
            i_issue_vld = 1'b0;
         end
         settle();
         if (in_lip && i_lip_vld && o_lip_rdy) in_lip = 1'b0;
         tick();
      end
      chk("random_complete", (n_issued >= 80) && !o_busy, 1);
      idle_inputs();
      repeat (3) tick();
   endtask

   // ---------------- main ----------------
   initial begin
      ops = '{7'o020, 7'o021, 7'o022, 7'o023, 7'o040, 7'o041};
      vecs[0] = '{7'o022, 1'b0, 3'd3, 3'd5, 3'd2, 16'h0000, 7'o022, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{7'o023, 1'b0, 3'd0, 3'd1, 3'd6, 16'h0000, 7'o023, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{7'o020, 1'b1, 3'd1, 3'd7, 3'd7, 16'hABCD, 7'o020, 16'hABCD, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{7'o021, 1'b1, 3'd7, 3'd2, 3'd3, 16'h1234, 7'o021, 16'h1234, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{7'o040, 1'b1, 3'd6, 3'd0, 3'd4, 16'h0F0F, 7'o040, 16'h0F0F, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{7'o041, 1'b1, 3'd2, 3'd3, 3'd1, 16'hFFFF, 7'o041, 16'hFFFF, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{7'o005, 1'b0, 3'd4, 3'd4, 3'd4, 16'h0000, 7'o000, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{7'o177, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 7'o000, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{7'o023, 1'b0, 3'd7, 3'd7, 3'd7, 16'h0000, 7'o023, 16'h0000, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      idle_inputs();
      i_issue_vld = 1'b1;
      i_parcel    = {7'o022, 3'd3, 3'd5, 3'd2};
      i_lip_vld   = 1'b1;
      #2 chk("reset_outs_async", outs(), RST_OUTS);
      repeat (3) tick();
      settle();
      chk("reset_outs_clocked", outs(), RST_OUTS);
      idle_code = dbg_state;
      tick();
      idle_inputs();
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 9; v++) run_vec(vecs[v]);
      settle();
      chk("vec_tail_idle", {o_busy, o_issue_rdy}, 2'b01);
      tick();

      seq_lip_late();
      seq_fu_stall();
      seq_resv();
      seq_reset_wb();
      run_random();

      chk("drain_writes", wr_q.size(), 0);
      chk("drain_gens", gen_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
